// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x3 keypad scan controller.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_POUND = 4'hB;

  // Controller phases: scan columns, confirm a press, wait for release,
  // then signal the MCU.
  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    INTR
  } state_t;

  typedef logic [1:0] row_idx_t;
  typedef logic [1:0] col_idx_t;

  // Largest of three cycle counts; sizes the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Keypad legend, indexed by the row and column of the closed switch.
  function automatic logic [3:0] key_map(input row_idx_t row, input col_idx_t col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      {2'd0, 2'd0}: code = 4'h1;
      {2'd0, 2'd1}: code = 4'h2;
      {2'd0, 2'd2}: code = 4'h3;
      {2'd1, 2'd0}: code = 4'h4;
      {2'd1, 2'd1}: code = 4'h5;
      {2'd1, 2'd2}: code = 4'h6;
      {2'd2, 2'd0}: code = 4'h7;
      {2'd2, 2'd1}: code = 4'h8;
      {2'd2, 2'd2}: code = 4'h9;
      {2'd3, 2'd0}: code = KEY_STAR;
      {2'd3, 2'd1}: code = 4'h0;
      {2'd3, 2'd2}: code = KEY_POUND;
      default:      code = 4'h0;
    endcase
    return code;
  endfunction

  // Index of the lowest set row line; lower rows win when several are high.
  function automatic row_idx_t first_row(input logic [NUM_ROWS-1:0] rows);
    row_idx_t idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (rows[i]) idx = row_idx_t'(i);
    end
    return idx;
  endfunction

  // Column rotation order 0 -> 1 -> 2 -> 0.
  function automatic col_idx_t next_col(input col_idx_t col);
    return (col == col_idx_t'(NUM_COLS - 1)) ? '0 : col + col_idx_t'(1);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Pin-level bundle between the keypad/MCU side and the scan controller.
interface keypad_scan_ctrl_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] rows;       // row sense lines, asynchronous to clk
  logic [NUM_COLS-1:0] cols;       // one-hot column drive
  logic [3:0]          key_code;   // last accepted key
  logic                key_valid;  // a key has been accepted since reset
  logic                interrupt;  // release interrupt to the MCU
  logic                intr_ack;   // MCU acknowledge, ends interrupt early

  // Keypad + MCU side.
  modport master (
    output rows, intr_ack,
    input  cols, key_code, key_valid, interrupt
  );

  // Scan controller side.
  modport slave (
    input  rows, intr_ack,
    output cols, key_code, key_valid, interrupt
  );

endinterface

// File: rtl/keypad_scan_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Shift the raw input through two stages; the second stage is the stable copy.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let meta and q update together at the
    // edge, so q takes the old meta value and a true two-stage chain results.
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: rotates the column drive, debounces a press on the
// sensed row, latches the key code and raises a bounded interrupt on release.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int INTR_CYCLES     = 6
) (
  input logic          clk,
  input logic          rst,
  keypad_scan_ctrl_if.slave kp
);

  // One counter serves every phase, so it is sized for the longest one.
  localparam int MAX_CYCLES = max3(SCAN_CYCLES, DEBOUNCE_CYCLES, INTR_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] INTR_LAST = CNT_W'(INTR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t              state,       state_d;
  logic [CNT_W-1:0]    cnt,         cnt_d;
  col_idx_t            col_idx,     col_idx_d;
  row_idx_t            cand_row,    cand_row_d;
  logic [3:0]          key_code_q,  key_code_d;
  logic                key_valid_q, key_valid_d;

  logic [NUM_ROWS-1:0] rows_s;
  logic                cand_high;

  // Only the synchronized copy of the row lines is ever looked at.
  sync2 #(
    .WIDTH(NUM_ROWS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.rows),
    .q   (rows_s)
  );

  // The candidate column is simply col_idx, which is frozen from the moment
  // a press is seen until the interrupt phase ends.
  assign cand_high = rows_s[cand_row];

  // State and datapath registers; reset also cancels a pending interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      cnt         <= '0;
      col_idx     <= '0;
      cand_row    <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      col_idx     <= col_idx_d;
      cand_row    <= cand_row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state and datapath decisions for the scan / debounce / release flow.
  always_comb begin
    // NOTE: every target gets its hold value first, so a branch that does not
    // mention a signal keeps it unchanged instead of inferring a latch.
    state_d     = state;
    cnt_d       = cnt;
    col_idx_d   = col_idx;
    cand_row_d  = cand_row;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;

    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_d = '0;
          if (|rows_s) begin
            cand_row_d = first_row(rows_s);
            state_d    = DEBOUNCE;
          end else begin
            col_idx_d = next_col(col_idx);
          end
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        if (!cand_high) begin
          // A single dropout means bounce: give up and move on.
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = next_col(col_idx);
        end else if (cnt == DEB_LAST) begin
          key_code_d  = key_map(cand_row, col_idx);
          key_valid_d = 1'b1;
          state_d     = HELD;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      HELD: begin
        // Count consecutive released cycles; any high cycle restarts the run.
        if (cand_high) begin
          cnt_d = '0;
        end else if (cnt == DEB_LAST) begin
          state_d = INTR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      INTR: begin
        if (kp.intr_ack || (cnt == INTR_LAST)) begin
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = next_col(col_idx);
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs decoded straight from the registers.
  assign kp.cols      = NUM_COLS'(1) << col_idx;
  assign kp.interrupt = (state == INTR);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scanning controller for the 4x3 keypad. It drives the column lines one at a time, samples and debounces the row lines, and latches a 4-bit key code. On key release it raises a stretched interrupt request to the MCU. It sits between the keypad pins and the MCU interrupt/input ports, and sequences all keypad activity in the driver.

## Interface
- SCAN_CYCLES, default 4: cycles each column is driven before moving to the next; must be ≥1.
- DEBOUNCE_CYCLES, default 8: consecutive stable cycles required to accept a press or a release; must be ≥1.
- INTR_CYCLES, default 6: maximum cycles `interrupt` stays high; must be ≥1.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rows  in  4  keypad row lines; 1 = key pressed in the driven column; asynchronous to clk.
- cols  out  3  one-hot column drive; active-high.
- key_code  out  4  last accepted key.
- key_valid  out  1  sticky flag; set when the first key is accepted after reset.
- interrupt  out  1  interrupt request to the MCU.
- intr_ack  in  1  MCU acknowledge; ends `interrupt` early.

## Operation
- `rows` passes through a 2-flop synchronizer to form `rows_s`. The FSM uses only `rows_s`.
- Reset values (clears mid-operation too, including any pending interrupt):
  - state = SCAN, col_idx = 0, cols = 3'b001
  - key_code = 0, key_valid = 0, interrupt = 0
  - counter = 0, all synchronizer flops = 0
- Key map, indexed [row][col]:
  - row0: 1, 2, 3
  - row1: 4, 5, 6
  - row2: 7, 8, 9
  - row3: * = 4'hA, 0 = 4'h0, # = 4'hB
- Several rows high at the sample point: the lowest row index wins.
- Several keys in different columns: the first column reached in the scan wins.
- **SCAN**
  - Drive `cols` = one-hot(col_idx); the counter counts 0..SCAN_CYCLES-1.
  - At count = SCAN_CYCLES-1:
    - rows_s ≠ 0: capture cand_row (priority-encoded) and cand_col = col_idx; go to DEBOUNCE.
    - rows_s = 0: col_idx advances 0→1→2→0 (wraps); counter clears.
- **DEBOUNCE**
  - The column stays driven; the counter restarts at 0.
  - rows_s[cand_row] = 1: counter increments.
  - rows_s[cand_row] = 0 in any cycle: abandon; advance col_idx and go to SCAN. key_code and key_valid are unchanged.
  - At count = DEBOUNCE_CYCLES-1 with the row still high: latch key_code, set key_valid, go to HELD.
- **HELD**
  - The column stays driven.
  - Each cycle with rows_s[cand_row] = 0 increments the counter; any cycle with the row high clears it.
  - At count = DEBOUNCE_CYCLES-1 with the row low: go to INTR.
  - Other keys pressed meanwhile are ignored.
- **INTR**
  - `interrupt` = 1; this is a Moore decode of the state.
  - The counter runs 0..INTR_CYCLES-1, then the FSM goes to SCAN.
  - intr_ack = 1 in any INTR cycle: go to SCAN on the next edge.
  - On exit, col_idx advances.
- intr_ack outside INTR has no effect.
- key_code is updated only on a new accepted key; it holds through later scans.

## Timing
- A `rows` change is visible in `rows_s` 2 cycles later.
- Press accept: key_code and key_valid update at the edge ending the DEBOUNCE_CYCLES-th stable cycle after the DEBOUNCE entry.
- Interrupt start: `interrupt` rises on the first cycle after DEBOUNCE_CYCLES consecutive released cycles in HELD.
- Interrupt length: high exactly INTR_CYCLES cycles, or fewer if acknowledged. With ack sampled high in cycle k of INTR, interrupt is low in cycle k+1.
- After SCAN exits, the next column is driven starting the next cycle.
- In SCAN each column is driven exactly SCAN_CYCLES cycles. A full idle scan period is 3·SCAN_CYCLES cycles.

## Structure
- Package `keypad_pkg`:
  - state enum {SCAN, DEBOUNCE, HELD, INTR}
  - NUM_ROWS = 4, NUM_COLS = 3
  - KEY_STAR = 4'hA, KEY_POUND = 4'hB
  - key-map function (row, col) → code
- Sub-module `sync2`: 2-flop synchronizer, parameterized width.
- One shared counter, width $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES, INTR_CYCLES)) + 1.

## Test plan
Parameters for all cases: SCAN_CYCLES = 4, DEBOUNCE_CYCLES = 8, INTR_CYCLES = 6.

1. **Reset and idle scan.** Hold rst for 2 cycles, rows = 0 → cols = 001 and all outputs 0; cols then rotates 001→010→100→001 every 4 cycles.
2. **Key 5.** Assert rows = 0010 while cols = 010, hold 30 cycles, then release → key_code = 5 and key_valid = 1. Interrupt is high 6 cycles, starting 2 + 8 cycles after the release. Scanning resumes with cols = 100.
3. **Bounce.** rows[0] high for 3 cycles after the DEBOUNCE entry, then low → no latch, key_valid stays 0, no interrupt, scanning resumes.
4. **Key map.** Press *, 0, # in sequence (row3, cols 0/1/2) → key_code = A, 0, B. Press rows = 0101 on col0 → key_code = 1.
5. **Early ack.** intr_ack = 1 in the 2nd interrupt cycle → interrupt lasts exactly 2 cycles; the FSM is in SCAN the next cycle.
6. **Reset mid-key.** Assert rst while in HELD with key 9 pressed, then release the key → all outputs 0 and no interrupt. A subsequent press of 9 is accepted normally.
